ds_heightmap_scanout: RTL and testbench

- Sits directly downstream of diamond_square_operator and replaces its tied-off x/y/z outputs as the path to the display.
- After the operator signals completion, walks the finished (2^DIM_POWER+1)² heightmap through a 1-cycle-latency read port.
- Maps each height to a 3-3-2 VGA colour and emits SCALE×SCALE replicated pixels over a valid/ready handshake to the VGA SRAM writer.
- Pulses frame_done once the whole map has been drawn.

---
 rtl/ds_pkg.sv | 29 ++
 rtl/ds_height_colormap.sv | 28 ++
 rtl/ds_heightmap_scanout.sv | 152 +++++++++++++++
 tb/tb_ds_heightmap_scanout.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared types and constants for the diamond-square heightmap display path.
package ds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    EMIT,
    DONE
  } ds_state_t;

  localparam logic [7:0] COL_WATER = 8'h03;
  localparam logic [7:0] COL_SAND  = 8'hFC;
  localparam logic [7:0] COL_GRASS = 8'h1C;
  localparam logic [7:0] COL_SNOW  = 8'hFF;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  function automatic logic [9:0] screen_coord(input int unsigned off,
                                              input int unsigned g,
                                              input int unsigned s,
                                              input int unsigned scale);
    int unsigned v;
    v = off + g * scale + s;
    return v[9:0];
  endfunction

endpackage

// File: rtl/ds_height_colormap.sv
// Combinational height -> RRRGGGBB colour banding (water/sand/grass/snow).
module ds_height_colormap
  import ds_pkg::*;
#(
  parameter int unsigned T_WATER = 64,
  parameter int unsigned T_SAND  = 96,
  parameter int unsigned T_GRASS = 192
) (
  input  logic [7:0] i_z,
  output logic [7:0] o_color
);

  // 9-bit limits so a threshold of 256 still classifies every height below it
  localparam logic [8:0] LIM_WATER = 9'(T_WATER);
  localparam logic [8:0] LIM_SAND  = 9'(T_SAND);
  localparam logic [8:0] LIM_GRASS = 9'(T_GRASS);

  logic [8:0] w_z;

  always_comb begin
    w_z = {1'b0, i_z};
    if (w_z < LIM_WATER)      o_color = COL_WATER;
    else if (w_z < LIM_SAND)  o_color = COL_SAND;
    else if (w_z < LIM_GRASS) o_color = COL_GRASS;
    else                      o_color = COL_SNOW;
  end

endmodule

// File: rtl/ds_heightmap_scanout.sv
// Walks the finished heightmap and streams SCALE x SCALE coloured pixel blocks to the VGA writer.
module ds_heightmap_scanout
  import ds_pkg::*;
#(
  parameter int unsigned DIM_POWER = 3,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned X_OFF     = 0,
  parameter int unsigned Y_OFF     = 0,
  parameter int unsigned T_WATER   = 64,
  parameter int unsigned T_SAND    = 96,
  parameter int unsigned T_GRASS   = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       rd_en,
  output logic [8:0] rd_col,
  output logic [8:0] rd_row,
  input  logic [7:0] rd_data,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] z,
  output logic [7:0] color,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned N    = (1 << DIM_POWER) + 1;
  localparam logic [8:0]  GMAX = 9'(N - 1);
  localparam logic [3:0]  SMAX = 4'(SCALE - 1);

  if (X_OFF + N * SCALE > SCREEN_W || Y_OFF + N * SCALE > SCREEN_H) begin : g_bad_placement
    $error("ds_heightmap_scanout: scaled heightmap does not fit on screen");
  end
  if (SCALE < 1 || SCALE > 8) begin : g_bad_scale
    $error("ds_heightmap_scanout: SCALE must be 1..8");
  end

  ds_state_t  r_state;
  logic [8:0] r_gx, r_gy;
  logic [3:0] r_sx, r_sy;
  logic       r_rd_en, r_pix_valid, r_busy, r_frame_done;
  logic [9:0] r_x, r_y;
  logic [7:0] r_z, r_color;

  logic [7:0] w_color;
  logic       w_xfer, w_sx_last, w_sy_last, w_gx_last, w_gy_last, w_blk_end;
  logic [3:0] w_sx_nxt, w_sy_nxt;
  logic [8:0] w_gx_nxt, w_gy_nxt;

  ds_height_colormap #(
    .T_WATER (T_WATER),
    .T_SAND  (T_SAND),
    .T_GRASS (T_GRASS)
  ) u_colormap (
    .i_z     (rd_data),
    .o_color (w_color)
  );

  always_comb begin
    w_xfer    = r_pix_valid & pix_ready;
    w_sx_last = (r_sx == SMAX);
    w_sy_last = (r_sy == SMAX);
    w_gx_last = (r_gx == GMAX);
    w_gy_last = (r_gy == GMAX);
    w_blk_end = w_sx_last & w_sy_last;
    w_sx_nxt  = w_sx_last ? '0 : r_sx + 4'd1;
    w_sy_nxt  = w_sx_last ? (w_sy_last ? '0 : r_sy + 4'd1) : r_sy;
    w_gx_nxt  = w_gx_last ? '0 : r_gx + 9'd1;
    w_gy_nxt  = w_gx_last ? r_gy + 9'd1 : r_gy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gx         <= '0;
      r_gy         <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_rd_en      <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_color      <= '0;
    end else begin
      r_rd_en      <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: if (start) begin
          r_gx    <= '0;
          r_gy    <= '0;
          r_sx    <= '0;
          r_sy    <= '0;
          r_busy  <= 1'b1;
          r_rd_en <= 1'b1;
          r_state <= REQ;
        end
        REQ: r_state <= CAP;
        CAP: begin
          r_z         <= rd_data;
          r_color     <= w_color;
          r_x         <= screen_coord(X_OFF, 32'(r_gx), 32'(r_sx), SCALE);
          r_y         <= screen_coord(Y_OFF, 32'(r_gy), 32'(r_sy), SCALE);
          r_pix_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: if (w_xfer) begin
          r_sx <= w_sx_nxt;
          r_sy <= w_sy_nxt;
          // Block complete: drop valid and either fetch the next point or finish
          if (w_blk_end) begin
            r_pix_valid <= 1'b0;
            if (w_gx_last && w_gy_last) begin
              r_frame_done <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_gx    <= w_gx_nxt;
              r_gy    <= w_gy_nxt;
              r_rd_en <= 1'b1;
              r_state <= REQ;
            end
          end else begin
            r_x <= screen_coord(X_OFF, 32'(r_gx), 32'(w_sx_nxt), SCALE);
            r_y <= screen_coord(Y_OFF, 32'(r_gy), 32'(w_sy_nxt), SCALE);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_col     = r_gx;
  assign rd_row     = r_gy;
  assign x          = r_x;
  assign y          = r_y;
  assign z          = r_z;
  assign color      = r_color;
  assign pix_valid  = r_pix_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ds_heightmap_scanout.sv
// Self-checking bench for ds_heightmap_scanout against a pixel-list reference model.
module tb_ds_heightmap_scanout;

  localparam int N = 9;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset, start, pix_ready;
  logic       rd_en, pix_valid, busy, frame_done;
  logic [8:0] rd_col, rd_row;
  logic [7:0] rd_data, z, color;
  logic [9:0] x, y;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  logic [7:0]  mem [N*N];
  logic [35:0] got_pix [$];
  logic [35:0] exp_pix [$];
  logic [17:0] got_rd  [$];

  logic        p_stall = 1'b0;
  logic        p_rd = 1'b0;
  logic [35:0] p_pix = '0;

  always #5 clk = ~clk;

  ds_heightmap_scanout #(
    .DIM_POWER (3),
    .SCALE     (S),
    .X_OFF     (0),
    .Y_OFF     (0),
    .T_WATER   (64),
    .T_SAND    (96),
    .T_GRASS   (192)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_en      (rd_en),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .x          (x),
    .y          (y),
    .z          (z),
    .color      (color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Column storage with one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[int'(rd_row) * N + int'(rd_col)];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Height band lookup: colour index = number of thresholds at or below h
  function automatic logic [7:0] model_color(input int h);
    int          thr [3] = '{64, 96, 192};
    logic [7:0]  pal [4] = '{8'h03, 8'hFC, 8'h1C, 8'hFF};
    int          k = 0;
    foreach (thr[i]) if (h >= thr[i]) k++;
    return pal[k];
  endfunction

  task automatic build_expected();
    exp_pix.delete();
    for (int gy = 0; gy < N; gy++)
      for (int gx = 0; gx < N; gx++)
        for (int sy = 0; sy < S; sy++)
          for (int sx = 0; sx < S; sx++) begin
            logic [9:0] ex, ey;
            ex = 10'(gx * S + sx);
            ey = 10'(gy * S + sy);
            exp_pix.push_back({ex, ey, mem[gy*N+gx], model_color(int'(mem[gy*N+gx]))});
          end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      p_stall = 1'b0;
      p_rd    = 1'b0;
    end else begin
      if (p_stall) check("hold_while_stalled", {pix_valid, x, y, z, color}, {1'b1, p_pix});
      if (p_rd) check("rd_en_back_to_back", rd_en, 1'b0);
      if (rd_en) got_rd.push_back({rd_col, rd_row});
      if (pix_valid && pix_ready) got_pix.push_back({x, y, z, color});
      if (frame_done) fd_count++;
      p_stall = pix_valid & ~pix_ready;
      p_pix   = {x, y, z, color};
      p_rd    = rd_en;
    end
  end

  task automatic compare_frame();
    check("pixel_count", got_pix.size(), N * N * S * S);
    check("read_count", got_rd.size(), N * N);
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      check($sformatf("pixel[%0d]", i), got_pix[i], exp_pix[i]);
    for (int i = 0; i < N * N && i < got_rd.size(); i++)
      check($sformatf("read[%0d]", i), got_rd[i], {9'(i % N), 9'(i / N)});
  endtask

  task automatic run_frame(input bit rnd, input bit mid, input int abort_at);
    int first = -1;
    got_pix.delete();
    got_rd.delete();
    fd_count = 0;
    build_expected();
    start = 1'b1;
    pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int idx = 0; idx < 6000; idx++) begin
      @(posedge clk); #1;
      start = mid && (idx == 150);
      if (idx == 0) begin
        check("busy_after_start", busy, 1'b1);
        check("first_rd_en", rd_en, 1'b1);
      end
      if (pix_valid && first < 0) first = idx;
      if (fd_count > 0) break;
      if (abort_at > 0 && got_pix.size() == abort_at - 1 && pix_valid) begin
        pix_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_pix_valid", pix_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_frame_done", fd_count, 0);
        check("abort_stays_idle", {busy, pix_valid, rd_en}, 3'b000);
        return;
      end
      if (idx == 5999) check("frame_timeout", fd_count, 1);
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("first_valid_latency", first, 2);
    repeat (4) @(posedge clk);
    #1;
    check("frame_done_once", fd_count, 1);
    check("busy_cleared", busy, 1'b0);
    check("valid_cleared", pix_valid, 1'b0);
    compare_frame();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    foreach (mem[i]) mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", {rd_en, rd_col, rd_row, x, y, z, color, pix_valid, busy, frame_done}, '0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Flat water map, always ready
    foreach (mem[i]) mem[i] = 8'd50;
    run_frame(1'b0, 1'b0, 0);
    if (got_pix.size() == N * N * S * S) begin
      check("first_pixel_xy", got_pix[0][35:16], {10'd0, 10'd0});
      check("last_pixel_xy", got_pix[N*N*S*S-1][35:16], {10'd17, 10'd17});
      check("flat_color_first", got_pix[0][7:0], 8'h03);
      check("flat_color_last", got_pix[N*N*S*S-1][7:0], 8'h03);
    end

    // Threshold edges on row 0, random elsewhere
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'd63;  mem[1] = 8'd64;  mem[2] = 8'd95;
    mem[3] = 8'd96;  mem[4] = 8'd191; mem[5] = 8'd192;
    run_frame(1'b0, 1'b0, 0);
    if (got_pix.size() > 5 * S * S) begin
      check("edge_z63", got_pix[0*S*S][7:0], 8'h03);
      check("edge_z64", got_pix[1*S*S][7:0], 8'hFC);
      check("edge_z95", got_pix[2*S*S][7:0], 8'hFC);
      check("edge_z96", got_pix[3*S*S][7:0], 8'h1C);
      check("edge_z191", got_pix[4*S*S][7:0], 8'h1C);
      check("edge_z192", got_pix[5*S*S][7:0], 8'hFF);
    end

    // Random backpressure with a stray start mid-frame
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    run_frame(1'b1, 1'b1, 0);

    // Abort on the 100th transfer, then a clean frame from (0,0)
    run_frame(1'b1, 1'b0, 100);
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    run_frame(1'b1, 1'b0, 0);
    if (got_pix.size() > 0) check("restart_origin", got_pix[0][35:16], {10'd0, 10'd0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
